// File: rtl/regfile_fwd_pkg.sv
// Shared definitions for the forwarding register file: FSM encodings,
// default widths and the lane-offset helper for packed forwarding buses.
package regfile_fwd_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  // INIT sweeps the array to zero after reset; RUN is normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Low bit of lane k in a bus made of equal lanes of width w.
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port's source selector. The youngest matching forwarding stage
// wins outright; if its data is not final the port stalls and returns zero
// rather than falling through to an older, stale value.
module regfile_fwd_mux
  import regfile_fwd_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NFWD = 3
) (
  input  logic               en_i,
  input  logic [AW-1:0]      rd_addr_i,
  input  logic [DW-1:0]      arr_data_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [DW-1:0]      wdata_i,
  input  logic [NFWD-1:0]    fwd_we_i,
  input  logic [NFWD-1:0]    fwd_valid_i,
  input  logic [NFWD*AW-1:0] fwd_addr_i,
  input  logic [NFWD*DW-1:0] fwd_data_i,
  output logic [DW-1:0]      rd_data_o,
  output logic               rd_stall_o
);

  logic hit;

  // Priority scan: stages young to old, then write-through, then array.
  always_comb begin
    rd_data_o  = '0;
    rd_stall_o = 1'b0;
    hit        = 1'b0;
    if (en_i && (rd_addr_i != '0)) begin
      for (int k = 0; k < NFWD; k++) begin
        if (!hit && fwd_we_i[k] && (fwd_addr_i[lane_lo(k, AW) +: AW] == rd_addr_i)) begin
          hit = 1'b1;
          if (fwd_valid_i[k]) begin
            rd_data_o = fwd_data_i[lane_lo(k, DW) +: DW];
          end else begin
            rd_stall_o = 1'b1;
          end
        end
      end
      if (!hit) begin
        if (we_i && (waddr_i == rd_addr_i)) begin
          rd_data_o = wdata_i;
        end else begin
          rd_data_o = arr_data_i;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// Integer register file for the ID stage with multi-stage forwarding,
// per-port load-use stall, HI/LO forwarding and a post-reset array clear.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int NRD  = 2,
  parameter int NFWD = 3
) (
  input  logic               clk,
  input  logic               rst,
  output logic               init_busy,
  input  logic [NRD*AW-1:0]  rd_addr,
  output logic [NRD*DW-1:0]  rd_data,
  output logic [NRD-1:0]     rd_stall,
  output logic               stall_o,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [DW-1:0]      wdata,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [DW-1:0]      hi_i,
  input  logic [DW-1:0]      lo_i,
  input  logic [NFWD-1:0]    fwd_hi_we,
  input  logic [NFWD-1:0]    fwd_lo_we,
  input  logic [NFWD*DW-1:0] fwd_hi,
  input  logic [NFWD*DW-1:0] fwd_lo,
  output logic [DW-1:0]      hi_o,
  output logic [DW-1:0]      lo_o
);

  localparam int DEPTH = 2 ** AW;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] hi_q, lo_q;
  logic          run;
  logic          hi_hit, lo_hit;

  assign run       = (state_q == ST_RUN);
  assign init_busy = !run;
  assign stall_o   = init_busy | (|rd_stall);

  // Next-state: INIT walks idx across the whole array, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        idx_d = idx_q;
      end
      default: begin
        state_d = ST_INIT;
        idx_d   = '0;
      end
    endcase
  end

  // State register; reset restarts the clear sweep from entry 0 in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Array write: clear sweep in INIT, commit port in RUN; a reset edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem_q[idx_q] <= '0;
      end else if (we && (waddr != '0)) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  // HI/LO registers: cleared on the first INIT cycle, committed in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        if (idx_q == '0) begin
          hi_q <= '0;
          lo_q <= '0;
        end
      end else begin
        if (hi_we) hi_q <= hi_i;
        if (lo_we) lo_q <= lo_i;
      end
    end
  end

  // One priority selector per read port.
  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];

    regfile_fwd_mux #(
      .DW  (DW),
      .AW  (AW),
      .NFWD(NFWD)
    ) u_mux (
      .en_i       (run),
      .rd_addr_i  (a),
      .arr_data_i (mem_q[a]),
      .we_i       (we),
      .waddr_i    (waddr),
      .wdata_i    (wdata),
      .fwd_we_i   (fwd_we),
      .fwd_valid_i(fwd_valid),
      .fwd_addr_i (fwd_addr),
      .fwd_data_i (fwd_data),
      .rd_data_o  (rd_data[p*DW +: DW]),
      .rd_stall_o (rd_stall[p])
    );
  end

  // HI forwarding: youngest writing stage, then commit write-through, then register.
  always_comb begin
    hi_o   = '0;
    hi_hit = 1'b0;
    if (run) begin
      for (int k = 0; k < NFWD; k++) begin
        if (!hi_hit && fwd_hi_we[k]) begin
          hi_hit = 1'b1;
          hi_o   = fwd_hi[lane_lo(k, DW) +: DW];
        end
      end
      if (!hi_hit) hi_o = hi_we ? hi_i : hi_q;
    end
  end

  // LO forwarding, independent of HI.
  always_comb begin
    lo_o   = '0;
    lo_hit = 1'b0;
    if (run) begin
      for (int k = 0; k < NFWD; k++) begin
        if (!lo_hit && fwd_lo_we[k]) begin
          lo_hit = 1'b1;
          lo_o   = fwd_lo[lane_lo(k, DW) +: DW];
        end
      end
      if (!lo_hit) lo_o = lo_we ? lo_i : lo_q;
    end
  end

endmodule
